// File: rtl/issue_scoreboard.sv
// In-order issue / out-of-order completion scoreboard with forwarding queries.
// Entries live in a circular buffer indexed by transaction id and retire through one commit port.

package ariane_pkg;
    typedef enum logic [3:0] {
        FuNone,
        FuLoad,
        FuStore,
        FuAlu,
        FuCtrlFlow,
        FuMult,
        FuCsr,
        FuFpu
    } fu_t;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception;
endpackage

module issue_scoreboard
    import ariane_pkg::*;
#(
    parameter int unsigned NR_ENTRIES  = 4,
    parameter int unsigned NR_WB_PORTS = 4,
    parameter int unsigned DATA_WIDTH  = 64,
    localparam int unsigned IDW        = $clog2(NR_ENTRIES)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   flush_i,
    input  logic                                   issue_valid_i,
    output logic                                   issue_ready_o,
    input  logic [4:0]                             issue_rd_i,
    input  fu_t                                    issue_fu_i,
    input  logic [63:0]                            issue_pc_i,
    output logic [IDW-1:0]                         issue_trans_id_o,
    input  logic [NR_WB_PORTS-1:0]                 wb_valid_i,
    input  logic [NR_WB_PORTS-1:0][IDW-1:0]        wb_trans_id_i,
    input  logic [NR_WB_PORTS-1:0][DATA_WIDTH-1:0] wb_data_i,
    input  exception [NR_WB_PORTS-1:0]             wb_ex_i,
    input  logic [4:0]                             rs1_i,
    input  logic [4:0]                             rs2_i,
    output logic                                   rs1_busy_o,
    output logic                                   rs2_busy_o,
    output logic                                   rs1_fwd_valid_o,
    output logic                                   rs2_fwd_valid_o,
    output logic [DATA_WIDTH-1:0]                  rs1_fwd_o,
    output logic [DATA_WIDTH-1:0]                  rs2_fwd_o,
    output logic                                   commit_valid_o,
    output logic [4:0]                             commit_rd_o,
    output fu_t                                    commit_fu_o,
    output logic [63:0]                            commit_pc_o,
    output logic [DATA_WIDTH-1:0]                  commit_data_o,
    output exception                               commit_ex_o,
    input  logic                                   commit_ack_i
);
    localparam int unsigned CntW = IDW + 1;

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic [4:0]            rd;
        fu_t                   fu;
        logic [63:0]           pc;
        logic [DATA_WIDTH-1:0] data;
        exception              ex;
    } entry_t;

    entry_t         mem_q [NR_ENTRIES];
    entry_t         mem_d [NR_ENTRIES];
    logic [IDW-1:0] head_q, head_d;
    logic [IDW-1:0] tail_q, tail_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic issue_fire;
    logic commit_fire;

    assign issue_ready_o    = (cnt_q < CntW'(NR_ENTRIES));
    assign issue_trans_id_o = tail_q;
    assign commit_valid_o   = mem_q[head_q].valid && mem_q[head_q].done;
    assign commit_rd_o      = mem_q[head_q].rd;
    assign commit_fu_o      = mem_q[head_q].fu;
    assign commit_pc_o      = mem_q[head_q].pc;
    assign commit_data_o    = mem_q[head_q].data;
    assign commit_ex_o      = mem_q[head_q].ex;

    assign issue_fire  = issue_valid_i && issue_ready_o;
    assign commit_fire = commit_ack_i && commit_valid_o;

    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;

        // Walk ports from highest to lowest so the lowest index is written last and wins.
        for (int p = int'(NR_WB_PORTS) - 1; p >= 0; p--) begin
            if (wb_valid_i[p] && mem_q[wb_trans_id_i[p]].valid) begin
                mem_d[wb_trans_id_i[p]].done = 1'b1;
                mem_d[wb_trans_id_i[p]].data = wb_data_i[p];
                mem_d[wb_trans_id_i[p]].ex   = wb_ex_i[p];
            end
        end

        if (commit_fire) begin
            mem_d[head_q].valid = 1'b0;
            head_d              = head_q + IDW'(1);
        end

        if (issue_fire) begin
            mem_d[tail_q].valid = 1'b1;
            mem_d[tail_q].done  = 1'b0;
            mem_d[tail_q].rd    = issue_rd_i;
            mem_d[tail_q].fu    = issue_fu_i;
            mem_d[tail_q].pc    = issue_pc_i;
            mem_d[tail_q].data  = '0;
            mem_d[tail_q].ex    = '0;
            tail_d              = tail_q + IDW'(1);
        end

        unique case ({issue_fire, commit_fire})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase

        if (flush_i) begin
            for (int i = 0; i < int'(NR_ENTRIES); i++) begin
                mem_d[i].valid = 1'b0;
            end
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NR_ENTRIES); i++) begin
                mem_q[i] <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int i = 0; i < int'(NR_ENTRIES); i++) begin
                mem_q[i] <= mem_d[i];
            end
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    logic [4:0]            rs     [2];
    logic                  busy   [2];
    logic                  fwd_v  [2];
    logic [DATA_WIDTH-1:0] fwd    [2];
    logic [IDW-1:0]        q_idx;

    assign rs[0] = rs1_i;
    assign rs[1] = rs2_i;

    // Scan oldest to youngest; a later match overrides, leaving the youngest writer.
    always_comb begin
        q_idx = '0;
        for (int op = 0; op < 2; op++) begin
            busy[op]  = 1'b0;
            fwd_v[op] = 1'b0;
            fwd[op]   = '0;
            for (int i = 0; i < int'(NR_ENTRIES); i++) begin
                q_idx = head_q + IDW'(i);
                if ((CntW'(i) < cnt_q) && mem_q[q_idx].valid && (mem_q[q_idx].rd == rs[op])
                    && (rs[op] != 5'd0)) begin
                    busy[op]  = !mem_q[q_idx].done;
                    fwd_v[op] = mem_q[q_idx].done;
                    fwd[op]   = mem_q[q_idx].done ? mem_q[q_idx].data : '0;
                end
            end
        end
    end

    assign rs1_busy_o      = busy[0];
    assign rs2_busy_o      = busy[1];
    assign rs1_fwd_valid_o = fwd_v[0];
    assign rs2_fwd_valid_o = fwd_v[1];
    assign rs1_fwd_o       = fwd[0];
    assign rs2_fwd_o       = fwd[1];

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Parametrised in-order-issue / out-of-order-completion scoreboard sitting between the issue stage and the writeback/commit stages. It generalises the fixed 4-entry, 4-writeback-port configuration to configurable depth, port count and data width. It tracks in-flight instructions in a circular buffer, accepts results from several functional units, and answers operand-busy and forwarding queries for the issue stage. It retires instructions in program order through a single commit port.

## Interface
- NR_ENTRIES, 4: buffer depth; power of two, ≥2.
- NR_WB_PORTS, 4: number of writeback ports, ≥1.
- DATA_WIDTH, 64: result width.
- IDW (localparam), $clog2(NR_ENTRIES): transaction-id width.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- flush_i  in  1  discard all entries.
- issue_valid_i  in  1  issue request.
- issue_ready_o  out  1  entry available.
- issue_rd_i  in  5  destination register.
- issue_fu_i  in  ariane_pkg::fu_t  functional unit.
- issue_pc_i  in  64  instruction PC.
- issue_trans_id_o  out  IDW  id assigned to the issuing instruction (= tail).
- wb_valid_i  in  NR_WB_PORTS  per-port result valid.
- wb_trans_id_i  in  NR_WB_PORTS×IDW  target entry.
- wb_data_i  in  NR_WB_PORTS×DATA_WIDTH  result.
- wb_ex_i  in  NR_WB_PORTS×ariane_pkg::exception  exception from the FU.
- rs1_i, rs2_i  in  5 each  operand register queries.
- rs1_busy_o, rs2_busy_o  out  1 each  youngest in-flight writer of rs has no result yet.
- rs1_fwd_valid_o, rs2_fwd_valid_o  out  1 each  youngest in-flight writer is done; data is forwardable.
- rs1_fwd_o, rs2_fwd_o  out  DATA_WIDTH each  forwarded result.
- commit_valid_o  out  1  head entry is done.
- commit_rd_o, commit_fu_o, commit_pc_o, commit_data_o, commit_ex_o  out  head entry fields.
- commit_ack_i  in  1  pop head.

## Operation
- Storage per entry: valid, done, rd, fu, pc, data, ex. Pointers: head, tail (IDW bits, wrap modulo NR_ENTRIES). Occupancy count has IDW+1 bits.
- Issue:
  - issue_ready_o = (count < NR_ENTRIES). Full means not ready, even if a commit occurs in the same cycle (no pass-through).
  - On valid && ready: entry[tail] ← {valid=1, done=0, fields, data=0, ex.valid=0}; tail++.
- Writeback:
  - For each port p with wb_valid_i[p] and entry[wb_trans_id_i[p]].valid at the start of the cycle: data ← wb_data_i[p], ex ← wb_ex_i[p], done ← 1.
  - Writeback to an invalid entry is ignored.
  - If several ports target the same id in one cycle, the lowest port index wins.
  - An entry being issued this cycle is not writable this cycle.
- Commit:
  - commit_valid_o = entry[head].valid && entry[head].done; commit_* fields show entry[head].
  - commit_ack_i while commit_valid_o clears entry[head].valid and increments head. Ack without commit_valid_o is ignored.
  - Count update: +1 on issue, −1 on commit; both in the same cycle leaves count unchanged.
- Operand query (rsN, evaluated on registered state only, no same-cycle writeback bypass):
  - Search valid entries from head toward tail for rd == rsN; the last match is the youngest writer.
  - No match, or rsN == 0: busy=0, fwd_valid=0, fwd=0.
  - Match with done=0: busy=1, fwd_valid=0.
  - Match with done=1: busy=0, fwd_valid=1, fwd = its data.
- Flush: all valid ← 0, head = tail = count = 0. Flush has priority over issue, writeback and commit in the same cycle.
- Reset values:
  - State: all entries invalid, pointers 0, count 0.
  - Outputs: issue_ready_o=1, issue_trans_id_o=0, commit_valid_o=0, all busy/fwd_valid 0, data outputs 0.

## Timing
- Issue → entry visible to busy query and commit logic: next cycle.
- Writeback → commit_valid_o / fwd_valid: next cycle.
- Minimum issue-to-commit: 2 cycles (issue at T, writeback at T+1, commit_valid at T+2).
- issue_ready_o, issue_trans_id_o, commit_*, and rs* outputs are combinational from registered state only. There are no input-to-output combinational paths except rs*_i → rs* outputs.
- Throughput: one issue and one commit per cycle, with up to NR_WB_PORTS writebacks per cycle.
- Asynchronous reset mid-operation clears all state immediately; the first issue after deassertion receives id 0.

## Test plan
- Fill/drain:
  - Stimulus: NR_ENTRIES=4, issue 4 (rd=1..4), no writeback.
  - Response: ids 0..3; issue_ready_o=0 after the 4th; commit_valid_o=0.
  - Then writeback all; commit 4 in order (rd 1,2,3,4); ready returns to 1.
- Out-of-order completion and wrap:
  - Stimulus: write back id 2 before id 0.
  - Response: commit_valid_o stays 0 until id 0 is done.
  - Then: run 10 issue/commit cycles; ids wrap 3→0 correctly.
- Forwarding:
  - Stimulus: issue rd=5 twice (ids 0,1); write back id 0 with 0xAA.
  - Response: rs1_i=5 gives busy=1, fwd_valid=0 (id 1 is youngest).
  - Then: write back id 1 with 0xBB; next cycle busy=0, fwd_valid=1, fwd=0xBB.
  - Also: rs1_i=0 with rd=0 in flight gives busy=0.
- Writeback collision:
  - Stimulus: ports 0 and 2 both write id 1 (0x11, 0x22) in one cycle.
  - Response: committed data = 0x11.
  - Also: writeback to an empty id 3 does not make it valid.
- Simultaneous events:
  - Stimulus: full buffer with commit_ack_i.
  - Response: issue_ready_o=0 that cycle, count becomes 3.
  - Stimulus: flush_i with issue_valid_i and wb_valid_i.
  - Response: next cycle count=0, commit_valid_o=0, next id=0.
- Async reset:
  - Stimulus: assert rst_i between clock edges with 3 entries live.
  - Response: outputs reach reset values before the next edge.
